parity_stream_unit: RTL and testbench

Streaming, parametrised parity generator/checker for the datapath. Accepts DATA_W-bit words over a valid/ready handshake and emits each word one cycle later with its parity bit, plus a running frame parity on the frame's last word. In check mode it compares a received parity bit per word and counts mismatches. It succeeds the fixed 4-bit combinational even-parity generator: width, frame length and parity sense are configurable, and the output is registered with backpressure.

---
 rtl/parity_stream_unit.sv | 190 +++++++++++++++++++
 tb/tb_parity_stream_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_stream_unit.sv
// parity_stream_unit: streaming parity generator/checker.
// Each accepted word is registered with its parity bit. The frame's last
// word also carries the running frame parity. In check mode the received
// parity bit is compared against the computed one, and the number of
// mismatching words delivered downstream is counted (saturating).
module parity_stream_unit #(
    parameter int DATA_W    = 8,
    parameter int MAX_FRAME = 16,
    parameter int ERR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              odd_sel,
    input  logic              chk_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_par,
    output logic              out_last,
    output logic              out_frame_par,
    output logic              out_err,
    output logic              out_ovr,
    output logic [ERR_W-1:0]  err_count
);

    localparam int CNT_W = $clog2(MAX_FRAME + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FRAME);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } state_t;

    // Frame tracking state
    state_t           state_q, state_d;
    logic             mode_odd_q, mode_odd_d;
    logic             mode_chk_q, mode_chk_d;
    logic             frame_acc_q, frame_acc_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    // Output register
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_par_q, out_par_d;
    logic              out_last_q, out_last_d;
    logic              out_fpar_q, out_fpar_d;
    logic              out_err_q, out_err_d;
    logic              out_ovr_q, out_ovr_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    // Per-word working values
    logic             accept;
    logic             out_xfer;
    logic             eff_odd;
    logic             eff_chk;
    logic             word_xor;
    logic             word_par;
    logic             acc_this;
    logic [CNT_W-1:0] cnt_this;
    logic             hit_max;
    logic             eof;

    // The output register frees up either when empty or when it drains this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    // Per-word parity, frame accumulation and end-of-frame detection.
    // The first word of a frame uses the live mode inputs; later words use the latched ones.
    always_comb begin
        eff_odd  = (state_q == ST_IDLE) ? odd_sel : mode_odd_q;
        eff_chk  = (state_q == ST_IDLE) ? chk_en  : mode_chk_q;
        word_xor = ^in_data;
        word_par = word_xor ^ eff_odd;
        acc_this = (state_q == ST_IDLE) ? word_xor : (frame_acc_q ^ word_xor);
        cnt_this = (state_q == ST_IDLE) ? CNT_W'(1) : (word_cnt_q + CNT_W'(1));
        hit_max  = (cnt_this == MAX_CNT);
        eof      = in_last || hit_max;
    end

    // Next-state logic for the frame FSM and the output register.
    always_comb begin
        state_d     = state_q;
        mode_odd_d  = mode_odd_q;
        mode_chk_d  = mode_chk_q;
        frame_acc_d = frame_acc_q;
        word_cnt_d  = word_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_par_d   = out_par_q;
        out_last_d  = out_last_q;
        out_fpar_d  = out_fpar_q;
        out_err_d   = out_err_q;
        out_ovr_d   = out_ovr_q;
        err_cnt_d   = err_cnt_q;

        if (accept) begin
            if (state_q == ST_IDLE) begin
                mode_odd_d = odd_sel;
                mode_chk_d = chk_en;
            end
            if (eof) begin
                state_d     = ST_IDLE;
                frame_acc_d = 1'b0;
                word_cnt_d  = '0;
            end else begin
                state_d     = ST_IN_FRAME;
                frame_acc_d = acc_this;
                word_cnt_d  = cnt_this;
            end
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_par_d   = word_par;
            out_last_d  = eof;
            out_fpar_d  = eof ? (acc_this ^ eff_odd) : 1'b0;
            out_err_d   = eff_chk && (in_par != word_par);
            out_ovr_d   = hit_max && !in_last;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        // Count erroneous words as they leave, holding at the maximum.
        if (out_xfer && out_err_q && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    // Frame FSM and mode/accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_odd_q  <= 1'b0;
            mode_chk_q  <= 1'b0;
            frame_acc_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_odd_q  <= mode_odd_d;
            mode_chk_q  <= mode_chk_d;
            frame_acc_q <= frame_acc_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    // Output word register; holds steady under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_par_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_fpar_q  <= 1'b0;
            out_err_q   <= 1'b0;
            out_ovr_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_par_q   <= out_par_d;
            out_last_q  <= out_last_d;
            out_fpar_q  <= out_fpar_d;
            out_err_q   <= out_err_d;
            out_ovr_q   <= out_ovr_d;
        end
    end

    // Saturating error counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_par       = out_par_q;
    assign out_last      = out_last_q;
    assign out_frame_par = out_fpar_q;
    assign out_err       = out_err_q;
    assign out_ovr       = out_ovr_q;
    assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_parity_stream_unit.sv
// Testbench for parity_stream_unit: scenario tasks drive the DUT and compare
// its outputs each cycle against a frame-level reference model built from
// ones-counts of the words in the current frame.
module tb_parity_stream_unit;

    localparam int DW    = 8;
    localparam int MAXF  = 4;
    localparam int EW    = 2;
    localparam int EMAX  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          odd_sel = 1'b0;
    logic          chk_en = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_par = 1'b0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_par;
    logic          out_last;
    logic          out_frame_par;
    logic          out_err;
    logic          out_ovr;
    logic [EW-1:0] err_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: expected output register contents
    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_data  = '0;
    logic          exp_par   = 1'b0;
    logic          exp_last  = 1'b0;
    logic          exp_fpar  = 1'b0;
    logic          exp_err   = 1'b0;
    logic          exp_ovr   = 1'b0;
    int            exp_cnt   = 0;
    // Reference model: the frame currently being received
    bit            in_frame  = 1'b0;
    bit            f_odd     = 1'b0;
    bit            f_chk     = 1'b0;
    int            f_len     = 0;
    int            f_ones    = 0;

    parity_stream_unit #(.DATA_W(DW), .MAX_FRAME(MAXF), .ERR_W(EW)) dut (
        .clk(clk), .rst_n(rst_n), .odd_sel(odd_sel), .chk_en(chk_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_par(in_par), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_par(out_par),
        .out_last(out_last), .out_frame_par(out_frame_par), .out_err(out_err),
        .out_ovr(out_ovr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] obs_vec();
        return {in_ready, out_valid, out_data, out_par, out_last,
                out_frame_par, out_err, out_ovr, err_count};
    endfunction

    function automatic logic [16:0] exp_vec();
        logic [EW-1:0] c;
        c = EW'(exp_cnt);
        return {(!exp_valid || out_ready), exp_valid, exp_data, exp_par, exp_last,
                exp_fpar, exp_err, exp_ovr, c};
    endfunction

    // When no word is held only in_ready, out_valid and err_count are defined.
    function automatic logic [16:0] cmp_mask();
        return exp_valid ? 17'h1FFFF : 17'h18003;
    endfunction

    // Apply one cycle's inputs half a clock before the sampling edge.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic p,
                         input logic l, input logic o, input logic c, input logic r);
        @(negedge clk);
        in_valid = v; in_data = d; in_par = p; in_last = l;
        odd_sel = o; chk_en = c; out_ready = r;
        #1;
    endtask

    // Advance the reference model by the rising edge that follows drive().
    task automatic model_commit();
        bit xfer, acc, eofw;
        int ones;
        xfer = exp_valid && out_ready;
        acc  = in_valid && (!exp_valid || out_ready);
        if (xfer && exp_err && exp_cnt < EMAX) exp_cnt++;
        if (acc) begin
            if (!in_frame) begin
                f_odd = odd_sel; f_chk = chk_en; f_len = 0; f_ones = 0;
            end
            ones   = $countones(in_data);
            f_len  = f_len + 1;
            f_ones = f_ones + ones;
            eofw   = in_last || (f_len == MAXF);
            exp_valid = 1'b1;
            exp_data  = in_data;
            exp_par   = logic'(ones % 2) ^ f_odd;
            exp_last  = eofw;
            exp_fpar  = eofw ? (logic'(f_ones % 2) ^ f_odd) : 1'b0;
            exp_err   = f_chk && (in_par != exp_par);
            exp_ovr   = (f_len == MAXF) && !in_last;
            in_frame  = !eofw;
        end else if (xfer) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_valid = 1'b0; exp_data = '0; exp_par = 1'b0; exp_last = 1'b0;
        exp_fpar = 1'b0; exp_err = 1'b0; exp_ovr = 1'b0; exp_cnt = 0;
        in_frame = 1'b0; f_len = 0; f_ones = 0; f_odd = 1'b0; f_chk = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if (obs_vec() !== 17'h10000) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs_vec(), 17'h10000);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_words();
        for (int w = 0; w <= 16; w++) begin
            if (w < 16) drive(1'b1, DW'(w), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            else        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if ((obs_vec() & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
                n_fail++;
                $display("FAIL single_word[%0d]: got %h want %h", w, obs_vec() & cmp_mask(), exp_vec() & cmp_mask());
            end
            model_commit();
        end
    endtask

    task automatic test_frame_modes();
        logic [DW-1:0] words [3];
        words[0] = 8'h03; words[1] = 8'h01; words[2] = 8'h07;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i <= 3; i++) begin
                // odd_sel only counts on the first word; later words toggle it.
                if (i < 3) drive(1'b1, words[i], 1'b0, logic'(i == 2),
                                 logic'(pass) ^ logic'(i % 2), 1'b0, 1'b1);
                else       drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                n_cmp++;
                if ((obs_vec() & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
                    n_fail++;
                    $display("FAIL frame_modes[p%0d w%0d]: got %h want %h", pass, i, obs_vec() & cmp_mask(), exp_vec() & cmp_mask());
                end
                model_commit();
            end
        end
    endtask

    task automatic test_check_mode();
        // 0xA5 with par 0 is correct, 0x01 with par 0 is wrong, then five bad single-word frames.
        logic [DW-1:0] d;
        for (int i = 0; i <= 7; i++) begin
            if (i == 0)      drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            else if (i == 1) drive(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            else if (i < 7) begin
                d = 8'h03;
                drive(1'b1, d, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            end else         drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if ((obs_vec() & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
                n_fail++;
                $display("FAIL check_mode[%0d]: got %h want %h", i, obs_vec() & cmp_mask(), exp_vec() & cmp_mask());
            end
            model_commit();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (err_count !== EW'(EMAX)) begin
            n_fail++;
            $display("FAIL err_saturate: got %0d want %0d", err_count, EMAX);
        end
        model_commit();
    endtask

    task automatic test_overflow();
        // Five words, no in_last: the fourth is forced last, the fifth opens an odd frame.
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) drive(1'b1, DW'(8'h11 * (i + 1)), 1'b0, 1'b0, logic'(i == 4), 1'b0, 1'b1);
            else       drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if ((obs_vec() & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
                n_fail++;
                $display("FAIL overflow[%0d]: got %h want %h", i, obs_vec() & cmp_mask(), exp_vec() & cmp_mask());
            end
            model_commit();
        end
        // Close the open frame so later tests start from IDLE.
        for (int i = 0; i < 2; i++) begin
            drive(logic'(i == 0), 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if ((obs_vec() & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
                n_fail++;
                $display("FAIL overflow_close[%0d]: got %h want %h", i, obs_vec() & cmp_mask(), exp_vec() & cmp_mask());
            end
            model_commit();
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] seq [6];
        logic [0:5] rdy;
        seq[0] = 8'h81; seq[1] = 8'h42; seq[2] = 8'h42; seq[3] = 8'h42;
        seq[4] = 8'h42; seq[5] = 8'h24;
        rdy = 6'b100011;
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) drive(1'b1, seq[i], 1'b0, logic'(i == 5), 1'b0, 1'b0, rdy[i]);
            else       drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if ((obs_vec() & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: got %h want %h", i, obs_vec() & cmp_mask(), exp_vec() & cmp_mask());
            end
            model_commit();
        end
    endtask

    task automatic test_back_to_back_random();
        logic v, l, r;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 3) == 0);
            r = (i < 100) ? 1'b1 : ($urandom_range(0, 9) < 7);
            drive(v, DW'($urandom_range(0, 255)), logic'($urandom_range(0, 1)), l,
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), r);
            n_cmp++;
            if ((obs_vec() & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", i, obs_vec() & cmp_mask(), exp_vec() & cmp_mask());
            end
            model_commit();
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, DW'(8'h07 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if ((obs_vec() & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
                n_fail++;
                $display("FAIL pre_reset[%0d]: got %h want %h", i, obs_vec() & cmp_mask(), exp_vec() & cmp_mask());
            end
            model_commit();
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs_vec() !== 17'h10000) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", obs_vec(), 17'h10000);
        end
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i <= 2; i++) begin
            if (i < 2) drive(1'b1, (i == 0) ? 8'h01 : 8'h30, 1'b0, logic'(i == 1), 1'b0, 1'b0, 1'b1);
            else       drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if ((obs_vec() & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got %h want %h", i, obs_vec() & cmp_mask(), exp_vec() & cmp_mask());
            end
            model_commit();
        end
    endtask

    initial begin
        test_reset();
        test_single_words();
        test_frame_modes();
        test_check_mode();
        test_overflow();
        test_backpressure();
        test_back_to_back_random();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
